// File: rtl/store_queue_ctrl.sv
// store_queue_ctrl
//   Store-path controller between the execute stage and the data-memory
//   write port. Incoming stores are aligned at acceptance (lane-replicated
//   data plus byte strobes), legal ones are queued in a DEPTH-entry FIFO and
//   then issued to memory one at a time through a registered req/ack port.
//   Misaligned or illegal-size stores are consumed, flagged with a one-cycle
//   error pulse and never reach memory.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   st_valid/st_ready   store request handshake (st_ready = FIFO not full)
//   st_addr/st_data     byte address and unaligned rs2 value
//   st_size             funct3[1:0]: 00 byte, 01 half, 10 word, 11 illegal
//   mem_req/mem_ack     memory write handshake
//   mem_addr            word-aligned write address
//   mem_wdata/mem_wstrb lane-replicated write data and byte enables
//   misalign_err        one-cycle pulse after a rejected store is consumed
//   err_addr            full address of the most recent rejected store
//   empty               nothing queued and no write outstanding (fence)
module store_queue_ctrl #(
    parameter int DEPTH = 2,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [AW-1:0] st_addr,
    input  logic [31:0]   st_data,
    input  logic [1:0]    st_size,
    output logic          mem_req,
    input  logic          mem_ack,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb,
    output logic          misalign_err,
    output logic [AW-1:0] err_addr,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic        err;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } align_t;

    // Lane alignment and legality for one store.
    function automatic align_t align_store(input logic [1:0]  size,
                                           input logic [1:0]  lo,
                                           input logic [31:0] data);
        align_t r;
        r.err   = 1'b0;
        r.wstrb = 4'b0000;
        r.wdata = data;
        case (size)
            2'b00: begin
                r.wdata = {4{data[7:0]}};
                r.wstrb = 4'b0001 << lo;
            end
            2'b01: begin
                r.wdata = {2{data[15:0]}};
                r.wstrb = lo[1] ? 4'b1100 : 4'b0011;
                r.err   = lo[0];
            end
            2'b10: begin
                r.wstrb = 4'b1111;
                r.err   = (lo != 2'b00);
            end
            default: begin
                r.err = 1'b1;
            end
        endcase
        return r;
    endfunction

    // FIFO storage: data only, never reset.
    logic [AW-1:0] fifo_addr_q  [DEPTH];
    logic [31:0]   fifo_wdata_q [DEPTH];
    logic [3:0]    fifo_wstrb_q [DEPTH];

    state_t        state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_wstrb_q, mem_wstrb_d;
    logic          misalign_err_q, misalign_err_d;
    logic [AW-1:0] err_addr_q, err_addr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          fifo_full;
    logic          fifo_empty;
    logic          accept;
    logic          push;
    logic          pop;
    logic          reject;
    align_t        al;
    logic [AW-1:0] st_addr_word;

    assign fifo_full    = (count_q == CW'(DEPTH));
    assign fifo_empty   = (count_q == '0);
    assign st_ready     = !fifo_full;
    assign accept       = st_valid && st_ready;
    assign al           = align_store(st_size, st_addr[1:0], st_data);
    assign push         = accept && !al.err;
    assign reject       = accept && al.err;
    assign st_addr_word = {st_addr[AW-1:2], 2'b00};

    // Issue FSM: pops the FIFO head into the output registers.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = fifo_addr_q[rd_ptr_q];
                    mem_wdata_d = fifo_wdata_q[rd_ptr_q];
                    mem_wstrb_d = fifo_wstrb_q[rd_ptr_q];
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    if (!fifo_empty) begin
                        pop         = 1'b1;
                        mem_addr_d  = fifo_addr_q[rd_ptr_q];
                        mem_wdata_d = fifo_wdata_q[rd_ptr_q];
                        mem_wstrb_d = fifo_wstrb_q[rd_ptr_q];
                    end else begin
                        mem_req_d   = 1'b0;
                        mem_wstrb_d = 4'b0000;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Queue bookkeeping and error capture.
    always_comb begin
        wr_ptr_d       = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d       = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d        = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
        misalign_err_d = reject;
        err_addr_d     = reject ? st_addr : err_addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_wstrb_q    <= '0;
            misalign_err_q <= 1'b0;
            err_addr_q     <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            mem_req_q      <= mem_req_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_wstrb_q    <= mem_wstrb_d;
            misalign_err_q <= misalign_err_d;
            err_addr_q     <= err_addr_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q]  <= st_addr_word;
            fifo_wdata_q[wr_ptr_q] <= al.wdata;
            fifo_wstrb_q[wr_ptr_q] <= al.wstrb;
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_wstrb    = mem_wstrb_q;
    assign misalign_err = misalign_err_q;
    assign err_addr     = err_addr_q;
    assign empty        = fifo_empty && (state_q == IDLE);

endmodule

// File: tb/tb_store_queue_ctrl.sv
module tb_store_queue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        misalign_err;
    logic [31:0] err_addr;
    logic        empty;

    int checks;
    int errors;

    store_queue_ctrl #(.DEPTH(2), .AW(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .st_valid     (st_valid),
        .st_ready     (st_ready),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .st_size      (st_size),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .misalign_err (misalign_err),
        .err_addr     (err_addr),
        .empty        (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled just after the falling edge.
    task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_size  = s;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got=%0h exp=0", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
        checks++; if (mem_wstrb !== 4'h0) begin errors++; $display("FAIL rst_mem_wstrb got=%b exp=0000", mem_wstrb); end
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL rst_misalign got=%0h exp=0", misalign_err); end
        checks++; if (err_addr !== 32'h0) begin errors++; $display("FAIL rst_err_addr got=%h exp=0", err_addr); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got=%0h exp=1", empty); end
        checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL rst_st_ready got=%0h exp=1", st_ready); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_byte;
        mem_ack = 1'b1;
        drive_store(32'h0000_1003, 32'h1234_56A5, 2'b00);
        @(negedge clk);
        st_valid = 1'b0;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL byte_req_early got=%0h exp=0", mem_req); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL byte_empty_queued got=%0h exp=0", empty); end
        @(negedge clk);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL byte_req got=%0h exp=1", mem_req); end
        checks++; if (mem_addr !== 32'h0000_1000) begin errors++; $display("FAIL byte_addr got=%h exp=00001000", mem_addr); end
        checks++; if (mem_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL byte_wdata got=%h exp=a5a5a5a5", mem_wdata); end
        checks++; if (mem_wstrb !== 4'b1000) begin errors++; $display("FAIL byte_wstrb got=%b exp=1000", mem_wstrb); end
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL byte_req_drop got=%0h exp=0", mem_req); end
        checks++; if (mem_wstrb !== 4'b0000) begin errors++; $display("FAIL byte_wstrb_clr got=%b exp=0000", mem_wstrb); end
        checks++; if (mem_addr !== 32'h0000_1000) begin errors++; $display("FAIL byte_addr_keep got=%h exp=00001000", mem_addr); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL byte_empty_after got=%0h exp=1", empty); end
    endtask

    task automatic test_align;
        mem_ack = 1'b1;
        drive_store(32'h0000_2002, 32'hFFFF_BEEF, 2'b01);
        @(negedge clk);
        drive_store(32'h0000_2004, 32'hDEAD_BEEF, 2'b10);
        @(negedge clk);
        st_valid = 1'b0;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL half_req got=%0h exp=1", mem_req); end
        checks++; if (mem_addr !== 32'h0000_2000) begin errors++; $display("FAIL half_addr got=%h exp=00002000", mem_addr); end
        checks++; if (mem_wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL half_wdata got=%h exp=beefbeef", mem_wdata); end
        checks++; if (mem_wstrb !== 4'b1100) begin errors++; $display("FAIL half_wstrb got=%b exp=1100", mem_wstrb); end
        @(negedge clk);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL word_req got=%0h exp=1", mem_req); end
        checks++; if (mem_addr !== 32'h0000_2004) begin errors++; $display("FAIL word_addr got=%h exp=00002004", mem_addr); end
        checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_wdata got=%h exp=deadbeef", mem_wdata); end
        checks++; if (mem_wstrb !== 4'b1111) begin errors++; $display("FAIL word_wstrb got=%b exp=1111", mem_wstrb); end
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL align_req_drop got=%0h exp=0", mem_req); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL align_empty got=%0h exp=1", empty); end
    endtask

    task automatic test_errors;
        logic [31:0] ea [3];
        logic [1:0]  es [3];
        ea[0] = 32'h0000_0101; es[0] = 2'b01;
        ea[1] = 32'h0000_0102; es[1] = 2'b10;
        ea[2] = 32'h0000_0000; es[2] = 2'b11;
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_store(ea[i], 32'hCAFE_F00D, es[i]);
            @(negedge clk);
            st_valid = 1'b0;
            checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL err%0d_pulse got=%0h exp=1", i, misalign_err); end
            checks++; if (err_addr !== ea[i]) begin errors++; $display("FAIL err%0d_addr got=%h exp=%h", i, err_addr, ea[i]); end
            checks++; if (empty !== 1'b1) begin errors++; $display("FAIL err%0d_empty got=%0h exp=1", i, empty); end
            @(negedge clk);
            checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL err%0d_pulse_end got=%0h exp=0", i, misalign_err); end
            checks++; if (err_addr !== ea[i]) begin errors++; $display("FAIL err%0d_addr_hold got=%h exp=%h", i, err_addr, ea[i]); end
            checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL err%0d_no_req got=%0h exp=0", i, mem_req); end
        end
    endtask

    task automatic test_backpressure;
        mem_ack = 1'b0;
        drive_store(32'h10, 32'hAAAA_0000, 2'b10);
        @(negedge clk);
        checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_a got=%0h exp=1", st_ready); end
        drive_store(32'h14, 32'hBBBB_0000, 2'b10);
        @(negedge clk);
        checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_b got=%0h exp=1", st_ready); end
        checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL bp_out_a got=%h exp=00000010", mem_addr); end
        drive_store(32'h18, 32'hCCCC_0000, 2'b10);
        @(negedge clk);
        checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL bp_full_c got=%0h exp=0", st_ready); end
        drive_store(32'h1C, 32'hDDDD_0000, 2'b10);
        @(negedge clk);
        checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_d got=%0h exp=0", st_ready); end
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL bp_hold_req got=%0h exp=1", mem_req); end
        checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL bp_hold_addr got=%h exp=00000010", mem_addr); end
        checks++; if (mem_wdata !== 32'hAAAA_0000) begin errors++; $display("FAIL bp_hold_wdata got=%h exp=aaaa0000", mem_wdata); end
        mem_ack = 1'b1;
        @(negedge clk);
        checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got=%0h exp=1", st_ready); end
        checks++; if (mem_addr !== 32'h14) begin errors++; $display("FAIL bp_write_b got=%h exp=00000014", mem_addr); end
        @(negedge clk);
        st_valid = 1'b0;
        checks++; if (mem_addr !== 32'h18) begin errors++; $display("FAIL bp_write_c got=%h exp=00000018", mem_addr); end
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL bp_req_c got=%0h exp=1", mem_req); end
        @(negedge clk);
        checks++; if (mem_addr !== 32'h1C) begin errors++; $display("FAIL bp_write_d got=%h exp=0000001c", mem_addr); end
        checks++; if (mem_wdata !== 32'hDDDD_0000) begin errors++; $display("FAIL bp_wdata_d got=%h exp=dddd0000", mem_wdata); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL bp_busy_d got=%0h exp=0", empty); end
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL bp_req_done got=%0h exp=0", mem_req); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL bp_empty_done got=%0h exp=1", empty); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a_exp;
        mem_ack = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k >= 2) begin
                a_exp = 32'h100 + 32'(4 * (k - 2));
                checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL b2b_req%0d got=%0h exp=1", k, mem_req); end
                checks++; if (mem_addr !== a_exp) begin errors++; $display("FAIL b2b_addr%0d got=%h exp=%h", k, mem_addr, a_exp); end
                checks++; if (mem_wdata !== (32'h5000_0000 + 32'(k - 2))) begin errors++; $display("FAIL b2b_wdata%0d got=%h exp=%h", k, mem_wdata, 32'h5000_0000 + 32'(k - 2)); end
            end
            checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got=%0h exp=1", k, st_ready); end
            drive_store(32'h100 + 32'(4 * k), 32'h5000_0000 + 32'(k), 2'b10);
            @(negedge clk);
        end
        st_valid = 1'b0;
        checks++; if (mem_addr !== 32'h118) begin errors++; $display("FAIL b2b_addr6 got=%h exp=00000118", mem_addr); end
        @(negedge clk);
        checks++; if (mem_addr !== 32'h11C) begin errors++; $display("FAIL b2b_addr7 got=%h exp=0000011c", mem_addr); end
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL b2b_req7 got=%0h exp=1", mem_req); end
        @(negedge clk);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got=%0h exp=1", empty); end
    endtask

    task automatic test_reset_mid;
        mem_ack = 1'b0;
        drive_store(32'h40, 32'h1111_1111, 2'b10);
        @(negedge clk);
        drive_store(32'h44, 32'h2222_2222, 2'b10);
        @(negedge clk);
        drive_store(32'h48, 32'h3333_3333, 2'b10);
        @(negedge clk);
        st_valid = 1'b0;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rmid_req_before got=%0h exp=1", mem_req); end
        checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL rmid_full_before got=%0h exp=0", st_ready); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rmid_req_async got=%0h exp=0", mem_req); end
        checks++; if (mem_wstrb !== 4'b0000) begin errors++; $display("FAIL rmid_wstrb got=%b exp=0000", mem_wstrb); end
        @(negedge clk);
        rst_n   = 1'b1;
        mem_ack = 1'b1;
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rmid_empty got=%0h exp=1", empty); end
        checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got=%0h exp=1", st_ready); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rmid_stale%0d got=%0h exp=0", i, mem_req); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_byte;
        test_align;
        test_errors;
        test_backpressure;
        test_back_to_back;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
